// File: rtl/link_pair_receiver_pkg.sv
// Shared types for the four-pair link receive path.
// Holds the pair symbol encoding, the deframer state enum, the abort cause
// codes, the default frame delimiter and the per-pair symbol decode helper.
package link_pair_receiver_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hD5;
  localparam int         NUM_LANES     = 2;   // lane A (1/2, 3/6), lane B (5/4, 7/8)
  localparam int         NUM_COPIES    = 2;   // redundant pairs per lane

  // Data symbols keep bit 1 clear, so bit 0 is the lane bit whenever bit 1 is 0.
  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_ONE  = 2'b01,
    SYM_IDLE = 2'b10,
    SYM_ERR  = 2'b11
  } pair_sym_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } rx_state_e;

  typedef logic [1:0] bad_code_t;
  localparam bad_code_t BAD_LINE = 2'd0;
  localparam bad_code_t BAD_ZLEN = 2'd1;
  localparam bad_code_t BAD_CSUM = 2'd2;
  localparam bad_code_t BAD_OVF  = 2'd3;

  typedef struct packed {
    logic      good;
    logic      bad;
    bad_code_t code;
  } frame_status_t;

  function automatic pair_sym_e decode_pair(input logic p, input logic n);
    case ({p, n})
      2'b10:   return SYM_ONE;
      2'b01:   return SYM_ZERO;
      2'b00:   return SYM_IDLE;
      default: return SYM_ERR;
    endcase
  endfunction

endpackage

// File: rtl/link_pair_receiver_pair_lane_decoder.sv
// One receive lane: two redundant differential pairs.
// Each pair passes a 2-flop synchronizer, is decoded to a symbol, and the two
// copies are compared; the registered lane symbol is data only when both
// copies carry the same bit, idle only when both are idle, error otherwise.
//   gclk, grst_n : clock, async active-low reset
//   p, n         : pair P/N lines, one bit per redundant copy
//   sym          : registered lane symbol
module pair_lane_decoder
  import link_pair_receiver_pkg::*;
(
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic [NUM_COPIES-1:0] p,
  input  logic [NUM_COPIES-1:0] n,
  output pair_sym_e             sym
);

  logic [1:0][NUM_COPIES-1:0] p_sync, n_sync;
  pair_sym_e                  s0, s1, lane_d;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      p_sync <= '0;
      n_sync <= '0;
    end else begin
      p_sync <= {p_sync[0], p};
      n_sync <= {n_sync[0], n};
    end
  end

  always_comb begin
    s0     = decode_pair(p_sync[1][0], n_sync[1][0]);
    s1     = decode_pair(p_sync[1][1], n_sync[1][1]);
    // Any disagreement between copies (including idle vs data) is an error.
    lane_d = (s0 == s1) ? s0 : SYM_ERR;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) sym <= SYM_IDLE;
    else         sym <= lane_d;
  end

endmodule

// File: rtl/link_pair_receiver.sv
// Receive endpoint of the four-pair link.
// Decodes lane A (pairs 1/2, 3/6) and lane B (pairs 5/4, 7/8) into one dibit
// per clock, hunts for the delimiter, deframes length-prefixed payloads with
// an 8-bit additive checksum (length + payload bytes), and queues payload
// bytes in a small FIFO drained with a valid/ready handshake.
//   Clock100Mhz, ResetN      : clock, async active-low reset
//   TIA_568B1..8             : pair P/N lines
//   RxData/RxValid/RxReady   : payload byte stream
//   RxLast                   : final byte of a frame (forced on tail at abort)
//   FrameGood/FrameBad       : one-cycle frame status pulses
//   BadCode                  : abort cause, valid with FrameBad
module link_pair_receiver
  import link_pair_receiver_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       Clock100Mhz,
  input  logic       ResetN,
  input  logic       TIA_568B1,
  input  logic       TIA_568B2,
  input  logic       TIA_568B3,
  input  logic       TIA_568B6,
  input  logic       TIA_568B5,
  input  logic       TIA_568B4,
  input  logic       TIA_568B7,
  input  logic       TIA_568B8,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxReady,
  output logic       RxLast,
  output logic       FrameGood,
  output logic       FrameBad,
  output logic [1:0] BadCode
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  // ---------------- lane decode ----------------
  logic [NUM_LANES-1:0][NUM_COPIES-1:0] pair_p, pair_n;
  pair_sym_e                            lane_sym [NUM_LANES];

  assign pair_p[0] = {TIA_568B3, TIA_568B1};
  assign pair_n[0] = {TIA_568B6, TIA_568B2};
  assign pair_p[1] = {TIA_568B7, TIA_568B5};
  assign pair_n[1] = {TIA_568B8, TIA_568B4};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pair_lane_decoder u_dec (
      .gclk   (Clock100Mhz),
      .grst_n (ResetN),
      .p      (pair_p[g]),
      .n      (pair_n[g]),
      .sym    (lane_sym[g])
    );
  end

  logic [1:0] sym_a, sym_b, dibit;
  logic       dib_vld, dib_idle, dib_err;

  always_comb begin
    sym_a    = lane_sym[0];
    sym_b    = lane_sym[1];
    dib_idle = (sym_a == SYM_IDLE) && (sym_b == SYM_IDLE);
    dib_vld  = !sym_a[1] && !sym_b[1];
    // Error covers ERR on either lane and one lane idle while the other carries data.
    dib_err  = !dib_idle && !dib_vld;
    dibit    = {sym_a[0], sym_b[0]};
  end

  // ---------------- FIFO ----------------
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [FIFO_DEPTH-1:0]      last_mem;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr, tail;
  logic [PTR_W:0]             cnt;
  logic                       pop, can_push, keep_tail;
  logic                       push, push_last, force_last;
  logic [7:0]                 byte_val;

  assign RxValid   = (cnt != '0);
  assign RxData    = mem[rd_ptr];
  assign RxLast    = RxValid & last_mem[rd_ptr];
  assign pop       = RxValid & RxReady;
  // A pop on the same edge frees a slot, so a full FIFO still takes the byte.
  assign can_push  = (cnt != FULL_CNT) || pop;
  // Tail survives this edge only if something remains after the pop.
  assign keep_tail = (cnt > {{PTR_W{1'b0}}, pop});
  assign tail      = wr_ptr - PTR_W'(1);

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      mem      <= '0;
      last_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]      <= byte_val;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (force_last && keep_tail) last_mem[tail] <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------- deframer ----------------
  rx_state_e     state, state_d;
  logic [5:0]    shreg, shreg_d;   // delimiter hunt history (6 older bits)
  logic [5:0]    acc, acc_d;       // byte assembly (3 older dibits)
  logic [1:0]    dcnt, dcnt_d;
  logic [7:0]    rem, rem_d;
  logic [7:0]    sum, sum_d;
  logic [7:0]    hunt_next;
  frame_status_t stat_q, stat_d;

  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    acc_d      = acc;
    dcnt_d     = dcnt;
    rem_d      = rem;
    sum_d      = sum;
    push       = 1'b0;
    push_last  = 1'b0;
    force_last = 1'b0;
    stat_d     = '{good: 1'b0, bad: 1'b0, code: BAD_LINE};
    hunt_next  = {shreg, dibit};
    byte_val   = {acc, dibit};

    case (state)
      ST_IDLE: begin
        if (dib_vld) begin
          shreg_d = hunt_next[5:0];
          state_d = ST_HUNT;
        end
      end
      ST_HUNT: begin
        if (dib_idle) begin
          shreg_d = '0;
          state_d = ST_IDLE;
        end else if (dib_err) begin
          shreg_d = '0;
        end else if (hunt_next == SYNC_BYTE) begin
          shreg_d = '0;
          dcnt_d  = '0;
          state_d = ST_LEN;
        end else begin
          shreg_d = hunt_next[5:0];
        end
      end
      default: begin  // ST_LEN, ST_PAYLOAD, ST_CHECK
        if (!dib_vld) begin
          stat_d     = '{good: 1'b0, bad: 1'b1, code: BAD_LINE};
          force_last = (state == ST_PAYLOAD);
          state_d    = ST_IDLE;
        end else begin
          acc_d  = {acc[3:0], dibit};
          dcnt_d = dcnt + 2'd1;
          if (dcnt == 2'd3) begin
            case (state)
              ST_LEN: begin
                if (byte_val == 8'd0) begin
                  stat_d  = '{good: 1'b0, bad: 1'b1, code: BAD_ZLEN};
                  state_d = ST_IDLE;
                end else begin
                  rem_d   = byte_val;
                  sum_d   = byte_val;
                  state_d = ST_PAYLOAD;
                end
              end
              ST_PAYLOAD: begin
                if (!can_push) begin
                  stat_d     = '{good: 1'b0, bad: 1'b1, code: BAD_OVF};
                  force_last = 1'b1;
                  state_d    = ST_IDLE;
                end else begin
                  push      = 1'b1;
                  push_last = (rem == 8'd1);
                  sum_d     = sum + byte_val;
                  rem_d     = rem - 8'd1;
                  if (rem == 8'd1) state_d = ST_CHECK;
                end
              end
              default: begin  // ST_CHECK
                if (byte_val == sum) stat_d = '{good: 1'b1, bad: 1'b0, code: BAD_LINE};
                else                 stat_d = '{good: 1'b0, bad: 1'b1, code: BAD_CSUM};
                state_d = ST_IDLE;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock100Mhz or negedge ResetN) begin
    if (!ResetN) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      acc    <= '0;
      dcnt   <= '0;
      rem    <= '0;
      sum    <= '0;
      stat_q <= '0;
    end else begin
      state  <= state_d;
      shreg  <= shreg_d;
      acc    <= acc_d;
      dcnt   <= dcnt_d;
      rem    <= rem_d;
      sum    <= sum_d;
      stat_q <= stat_d;
    end
  end

  assign FrameGood = stat_q.good;
  assign FrameBad  = stat_q.bad;
  assign BadCode   = stat_q.code;

endmodule

// File: tb/tb_link_pair_receiver.sv
module tb_link_pair_receiver;

  logic       clk, rst_n;
  logic       b1, b2, b3, b6, b5, b4, b7, b8;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_last;
  logic       frame_good, frame_bad;
  logic [1:0] bad_code;

  link_pair_receiver #(.SYNC_BYTE(8'hD5), .FIFO_DEPTH(4)) dut (
    .Clock100Mhz (clk),
    .ResetN      (rst_n),
    .TIA_568B1   (b1),
    .TIA_568B2   (b2),
    .TIA_568B3   (b3),
    .TIA_568B6   (b6),
    .TIA_568B5   (b5),
    .TIA_568B4   (b4),
    .TIA_568B7   (b7),
    .TIA_568B8   (b8),
    .RxData      (rx_data),
    .RxValid     (rx_valid),
    .RxReady     (rx_ready),
    .RxLast      (rx_last),
    .FrameGood   (frame_good),
    .FrameBad    (frame_bad),
    .BadCode     (bad_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {logic [7:0] data; logic last;} exp_byte_t;
  typedef struct {logic good; logic [1:0] code;} exp_stat_t;
  exp_byte_t bq[$];
  exp_stat_t sq[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic l);
    exp_byte_t e;
    e.data = d; e.last = l;
    bq.push_back(e);
  endtask

  task automatic exp_stat(input logic g, input logic [1:0] c);
    exp_stat_t e;
    e.good = g; e.code = c;
    sq.push_back(e);
  endtask

  // Monitor: samples mid-low-phase, after the driver has settled its inputs.
  initial begin
    exp_byte_t eb;
    exp_stat_t es;
    forever begin
      @(negedge clk);
      #2;
      if (rx_valid && rx_ready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got=%0h", rx_data);
        end else begin
          eb = bq.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, eb.data});
          chk("rx_last", {31'd0, rx_last}, {31'd0, eb.last});
        end
      end
      if (frame_good || frame_bad) begin
        chk("good_bad_exclusive", {31'd0, frame_good & frame_bad}, 32'd0);
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_status: good=%0b bad=%0b code=%0d", frame_good, frame_bad, bad_code);
        end else begin
          es = sq.pop_front();
          chk("frame_good", {31'd0, frame_good}, {31'd0, es.good});
          if (!es.good) chk("bad_code", {30'd0, bad_code}, {30'd0, es.code});
        end
      end
    end
  end

  task automatic drive_dibit(input logic a, input logic b);
    @(negedge clk);
    b1 = a; b2 = ~a; b3 = a; b6 = ~a;
    b5 = b; b4 = ~b; b7 = b; b8 = ~b;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      {b1, b2, b3, b6, b5, b4, b7, b8} = 8'h00;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 3; i >= 0; i--) drive_dibit(v[2*i+1], v[2*i]);
  endtask

  task automatic send_head(input logic [7:0] len);
    send_byte(8'h55);
    send_byte(8'hD5);
    send_byte(len);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((bq.size() + sq.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", bq.size() + sq.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data"},    {24'd0, rx_data},    32'd0);
    chk({tag, "_rx_valid"},   {31'd0, rx_valid},   32'd0);
    chk({tag, "_rx_last"},    {31'd0, rx_last},    32'd0);
    chk({tag, "_frame_good"}, {31'd0, frame_good}, 32'd0);
    chk({tag, "_frame_bad"},  {31'd0, frame_bad},  32'd0);
    chk({tag, "_bad_code"},   {30'd0, bad_code},   32'd0);
  endtask

  task automatic good_frame();
    exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b1);
    exp_stat(1'b1, 2'd0);
    send_head(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
    drive_idle(8);
    wait_drain(100);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_ready = 1'b1;
    {b1, b2, b3, b6, b5, b4, b7, b8} = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    drive_idle(4);

    // Good frame: 11 22 33, sum 69
    good_frame();

    // Checksum mismatch: bytes still delivered, code 2
    exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b1);
    exp_stat(1'b0, 2'd2);
    send_head(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h68);
    drive_idle(8);
    wait_drain(100);

    // Zero length, then a good frame
    exp_stat(1'b0, 2'd1);
    send_head(8'h00);
    drive_idle(6);
    wait_drain(100);
    good_frame();

    // Pair 5/4 idle during second payload byte; first byte gets RxLast forced
    rx_ready = 1'b0;
    exp_byte(8'h11, 1'b1);
    exp_stat(1'b0, 2'd0);
    send_head(8'h03);
    send_byte(8'h11);
    drive_dibit(1'b0, 1'b0);
    drive_dibit(1'b1, 1'b0);
    b5 = 1'b0; b4 = 1'b0;
    drive_idle(10);
    rx_ready = 1'b1;
    wait_drain(100);

    // Overflow: 4 queued, 5th dropped, code 3, tail forced last
    rx_ready = 1'b0;
    exp_byte(8'h01, 1'b0); exp_byte(8'h02, 1'b0); exp_byte(8'h03, 1'b0); exp_byte(8'h04, 1'b1);
    exp_stat(1'b0, 2'd3);
    send_head(8'h06);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    drive_idle(10);
    rx_ready = 1'b1;
    wait_drain(100);
    drive_idle(4);
    chk("valid_after_overflow_drain", {31'd0, rx_valid}, 32'd0);

    // Lane A copies disagree in the length field
    exp_stat(1'b0, 2'd0);
    send_byte(8'h55);
    send_byte(8'hD5);
    @(negedge clk);
    b1 = 1'b1; b2 = 1'b0; b3 = 1'b0; b6 = 1'b1;
    b5 = 1'b0; b4 = 1'b1; b7 = 1'b0; b8 = 1'b1;
    drive_idle(8);
    wait_drain(100);

    // Reset mid-payload: everything cleared, no status pulse
    rx_ready = 1'b0;
    send_head(8'h03);
    send_byte(8'h11);
    drive_dibit(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    {b1, b2, b3, b6, b5, b4, b7, b8} = 8'h00;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    drive_idle(6);
    chk("valid_after_midreset", {31'd0, rx_valid}, 32'd0);

    // Recovery
    good_frame();

    drive_idle(6);
    chk("byte_queue_empty", bq.size(), 32'd0);
    chk("status_queue_empty", sq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
